// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment patterns {a,b,c,d,e,f,g,dp} and segment bit indices.
package seg7_pkg;
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;
  localparam logic [7:0] SEG_A_HEX = 8'hEE;
  localparam logic [7:0] SEG_B_HEX = 8'h3E;
  localparam logic [7:0] SEG_C_HEX = 8'h9C;
  localparam logic [7:0] SEG_D_HEX = 8'h7A;
  localparam logic [7:0] SEG_E_HEX = 8'h9E;
  localparam logic [7:0] SEG_F_HEX = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_DP = 0;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to segments a..g.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  localparam logic [7:0] LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                      SEG_8, SEG_9, SEG_A_HEX, SEG_B_HEX, SEG_C_HEX, SEG_D_HEX,
                                      SEG_E_HEX, SEG_F_HEX};
  assign seg = LUT[nib][SEG_A:SEG_G];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment scanner with frame-aligned
// value commit, per-digit dp, forced blanking and leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pdata_q, pdata_d, adata_q, adata_d, hi;
  logic [N_DIGITS-1:0] pdp_q, pdp_d, adp_q, adp_d, pbl_q, pbl_d, abl_q, abl_d, an_q, an_d;
  logic plz_q, plz_d, alz_q, alz_d, tick, wrap, lzb, fs_q;
  logic [7:0] seg_q, seg_d;
  logic [6:0] dec;
  seg7_hex_decode u_dec (.nib(hi[3:0]), .seg(dec));
  // Outputs are computed from next-state idx/active so they land on the tick edge itself.
  always_comb begin
    tick = pcnt_q == PW'(REFRESH_DIV - 1);
    wrap = tick && idx_q == IW'(N_DIGITS - 1);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    pdata_d = load ? data_in : pdata_q;
    pdp_d = load ? dp_in : pdp_q;
    pbl_d = load ? blank_in : pbl_q;
    plz_d = load ? lz_en : plz_q;
    adata_d = wrap ? pdata_d : adata_q;
    adp_d = wrap ? pdp_d : adp_q;
    abl_d = wrap ? pbl_d : abl_q;
    alz_d = wrap ? plz_d : alz_q;
    an_d = N_DIGITS'(1) << idx_d;
    hi = adata_d >> {idx_d, 2'b00};
    lzb = alz_d && idx_d != '0 && hi == '0;
    seg_d = |(abl_d & an_d) ? SEG_BLANK : {lzb ? 7'h00 : dec, |(adp_d & an_d)};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      idx_q <= IW'(N_DIGITS - 1);
      pdata_q <= '0;
      pdp_q <= '0;
      pbl_q <= '0;
      plz_q <= 1'b0;
      adata_q <= '0;
      adp_q <= '0;
      abl_q <= '0;
      alz_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q <= '0;
      fs_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q <= idx_d;
      pdata_q <= pdata_d;
      pdp_q <= pdp_d;
      pbl_q <= pbl_d;
      plz_q <= plz_d;
      adata_q <= adata_d;
      adp_q <= adp_d;
      abl_q <= abl_d;
      alz_q <= alz_d;
      if (tick) begin
        seg_q <= seg_d;
        an_q <= an_d;
      end
      fs_q <= wrap;
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, decode, commit alignment, lz and blanking.
module tb_seg7_scan_driver;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, lz_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic [7:0] seg, seg1;
  logic [3:0] an;
  logic [0:0] an1;
  logic fs, fs1;
  int checks = 0, errors = 0;
  seg7_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(3)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .an(an), .frame_start(fs));
  seg7_scan_driver #(.N_DIGITS(1), .REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in[3:0]), .dp_in(dp_in[0]),
    .blank_in(blank_in[0]), .lz_en(lz_en), .seg(seg1), .an(an1), .frame_start(fs1));
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_fs(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1);
      seen = fs;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask
  task automatic chk_frame(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_an%0d", tag, i), 32'(an), 32'(1 << i));
      chk($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(exp[8*i +: 8]));
      if (i < 3) cyc(3);
    end
  endtask
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
    data_in = d;
    dp_in = dp;
    blank_in = bl;
    lz_en = lz;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_fs", 32'(fs), 32'h0);
    chk("rst_an1", 32'(an1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("n1_an", 32'(an1), 32'h1);
    chk("n1_fs", 32'(fs1), 32'h1);
    chk("n1_seg", 32'(seg1), 32'hFC);
    cyc(1);
    chk("idle_an", 32'(an), 32'h0);
    chk("idle_seg", 32'(seg), 32'h00);
    chk("n1_fs2", 32'(fs1), 32'h1);
    cyc(1);
    chk("first_fs", 32'(fs), 32'h1);
    cyc(1);
    chk("fs_pulse", 32'(fs), 32'h0);
    cyc(2);
    chk("idle_d1_an", 32'(an), 32'h2);
    cyc(6);
    chk("idle_d3_an", 32'(an), 32'h8);
    chk("idle_d3_seg", 32'(seg), 32'hFC);
    do_load(16'hA5F0, 4'b0100, 4'b0000, 1'b0);
    wait_fs("fs_a5f0");
    chk_frame("a5f0", 32'hEEB78EFC);
    do_load(16'h0030, 4'b0000, 4'b0000, 1'b1);
    wait_fs("fs_lz30");
    chk_frame("lz30", 32'h0000F2FC);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    wait_fs("fs_lz0");
    chk_frame("lz0", 32'h000000FC);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b0);
    wait_fs("fs_zero");
    cyc(6);
    chk("mid_an", 32'(an), 32'h4);
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    chk("mid_old_d2", 32'(seg), 32'hFC);
    cyc(2);
    chk("mid_old_d3_an", 32'(an), 32'h8);
    chk("mid_old_d3", 32'(seg), 32'hFC);
    wait_fs("fs_1111");
    chk_frame("f1111", 32'h60606060);
    wait_fs("fs_pre2");
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    do_load(16'h5678, 4'b0000, 4'b0000, 1'b0);
    chk("old_kept", 32'(seg), 32'h60);
    wait_fs("fs_5678");
    chk_frame("f5678", 32'hB6BEE0FE);
    cyc(2);
    data_in = 16'h9ABC;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("bypass_fs", 32'(fs), 32'h1);
    chk_frame("f9abc", 32'hF6EE3E9C);
    wait_fs("fs_9abc2");
    chk("pend_upd", 32'(seg), 32'h9C);
    do_load(16'h0000, 4'b0010, 4'b0010, 1'b0);
    wait_fs("fs_blank");
    chk_frame("blank", 32'hFCFC00FC);
    wait_fs("fs_blank2");
    cyc(3);
    chk("blank_an", 32'(an), 32'h2);
    chk("blank_seg", 32'(seg), 32'h00);
    cyc(1);
    rst = 1'b1;
    #1;
    chk("arst_seg", 32'(seg), 32'h00);
    chk("arst_an", 32'(an), 32'h0);
    chk("arst_fs", 32'(fs), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_fs("fs_after_rst");
    chk_frame("lost", 32'hFCFCFCFC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
